mfp_ahb_dma: RTL and testbench

- Single-channel AHB-lite bus master (initiator) that copies a block of 32-bit words from a source address to a destination address.
- Drives the same HADDR/HTRANS/HWRITE/HWDATA bus that the system interconnect decodes to boot RAM, program RAM, GPIO, VRAM, SRAM and SD slaves.
- Main use: fast SRAM-to-VRAM frame blits and buffer copies without CPU load/store loops.
- Control comes from a simple command interface, driven by a GPIO-mapped register block.

---
 rtl/mfp_ahb_dma.sv | 182 ++++++++++++++++++
 tb/tb_mfp_ahb_dma.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_dma.sv
// mfp_ahb_dma: single-channel AHB-lite master that copies a block of 32-bit words from src to dst.
// Define MFP_AHB_DMA_FILL_EN to add fill mode (a latched pattern written to LEN words, no reads).
module mfp_ahb_dma #(
  parameter int unsigned LEN_W     = 16,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             CMD_START,
  input  logic [31:0]      CMD_SRC,
  input  logic [31:0]      CMD_DST,
  input  logic [LEN_W-1:0] CMD_LEN,
  input  logic             CMD_FILL,
  input  logic [31:0]      CMD_PATTERN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_d, busy_d, done_d, hwrite_d;
  logic [31:0]      haddr_d, hwdata_d, wdata;
  logic [1:0]       htrans_d;
  logic             accept, start_fill, fill_mode;

  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  assign accept = (state_q == S_IDLE) && CMD_START;

`ifdef MFP_AHB_DMA_FILL_EN
  logic        fill_q;
  logic [31:0] pattern_q;

  // Fill selection and pattern are captured once per accepted command
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fill_q    <= 1'b0;
      pattern_q <= 32'd0;
    end else if (accept) begin
      fill_q    <= CMD_FILL;
      pattern_q <= CMD_PATTERN;
    end
  end

  assign start_fill = CMD_FILL;
  assign fill_mode  = fill_q;
  assign wdata      = fill_q ? pattern_q : data_q;
`else
  logic unused_fill;
  assign unused_fill = ^{CMD_FILL, CMD_PATTERN};
  assign start_fill  = 1'b0;
  assign fill_mode   = 1'b0;
  assign wdata       = data_q;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (CMD_START) begin
        if (CMD_LEN == '0)    state_d = S_FIN;
        else if (start_fill)  state_d = S_WR_A;
        else                  state_d = S_RD_A;
      end
      S_RD_A: if (HREADY) state_d = S_RD_D;
      S_RD_D: if (HREADY) state_d = HRESP ? S_FIN : S_WR_A;
      S_WR_A: if (HREADY) state_d = S_WR_D;
      S_WR_D: if (HREADY) begin
        if (HRESP || cnt_q == LEN_W'(1)) state_d = S_FIN;
        else if (fill_mode)              state_d = S_WR_A;
        else                             state_d = S_RD_A;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates plus bus outputs prepared for the state being entered
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    err_d    = ERR;
    haddr_d  = HADDR;
    hwrite_d = HWRITE;
    hwdata_d = HWDATA;
    htrans_d = HT_IDLE;
    case (state_q)
      S_IDLE: if (CMD_START) begin
        src_d = {CMD_SRC[31:2], 2'b00};
        dst_d = {CMD_DST[31:2], 2'b00};
        cnt_d = CMD_LEN;
        err_d = 1'b0;
      end
      S_RD_D: if (HREADY) begin
        if (HRESP) err_d  = 1'b1;
        else       data_d = HRDATA;
      end
      S_WR_D: if (HREADY) begin
        if (HRESP) begin
          err_d = 1'b1;
        end else begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: ;
    endcase
    case (state_d)
      S_RD_A: begin
        htrans_d = HT_NONSEQ;
        haddr_d  = src_d;
        hwrite_d = 1'b0;
      end
      S_WR_A: begin
        htrans_d = HT_NONSEQ;
        haddr_d  = dst_d;
        hwrite_d = 1'b1;
      end
      S_WR_D:  hwdata_d = wdata;
      default: ;
    endcase
    busy_d = (state_d inside {S_RD_A, S_RD_D, S_WR_A, S_WR_D});
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_q  <= 32'd0;
      dst_q  <= 32'd0;
      data_q <= 32'd0;
      cnt_q  <= '0;
      ERR    <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      HADDR  <= 32'd0;
      HTRANS <= HT_IDLE;
      HWRITE <= 1'b0;
      HWDATA <= 32'd0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      ERR    <= err_d;
      BUSY   <= busy_d;
      DONE   <= done_d;
      HADDR  <= haddr_d;
      HTRANS <= htrans_d;
      HWRITE <= hwrite_d;
      HWDATA <= hwdata_d;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_dma.sv
// tb_mfp_ahb_dma: randomized and directed bench for mfp_ahb_dma with a behavioural AHB slave memory.
module tb_mfp_ahb_dma;

  localparam int unsigned LEN_W = 16;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic             CMD_START = 1'b0;
  logic [31:0]      CMD_SRC = 32'd0;
  logic [31:0]      CMD_DST = 32'd0;
  logic [LEN_W-1:0] CMD_LEN = '0;
  logic             CMD_FILL = 1'b0;
  logic [31:0]      CMD_PATTERN = 32'd0;
  logic             BUSY, DONE, ERR, HWRITE, HMASTLOCK;
  logic [31:0]      HADDR, HWDATA;
  logic [1:0]       HTRANS;
  logic [2:0]       HSIZE, HBURST;
  logic [3:0]       HPROT;
  logic [31:0]      HRDATA = 32'd0;
  logic             HREADY = 1'b1;
  logic             HRESP = 1'b0;

  mfp_ahb_dma dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .CMD_START(CMD_START), .CMD_SRC(CMD_SRC),
    .CMD_DST(CMD_DST), .CMD_LEN(CMD_LEN), .CMD_FILL(CMD_FILL), .CMD_PATTERN(CMD_PATTERN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int passed = 0;
  int total  = 0;

  // Slave memory, transaction logs and knobs
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
  int          wait_cfg = 0, err_on_wr = 0, wr_seen = 0, n_nonseq = 0, stab_errs = 0, busy_bad = 0;
  bit          pend = 1'b0, pend_wr = 1'b0, first_dp = 1'b0;
  logic [31:0] pend_addr = 32'd0, hold_wdata = 32'd0;
  int          wcnt = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
  endfunction

  // AHB-lite slave: responds on the falling edge so the DUT samples settled values
  always @(negedge HCLK) begin
    HRESP = 1'b0;
    if (!HRESETn) begin
      pend   = 1'b0;
      HREADY = 1'b1;
    end else if (pend) begin
      if (first_dp) begin
        hold_wdata = HWDATA;
        first_dp   = 1'b0;
      end
      if (HTRANS !== 2'b00 || HADDR !== pend_addr || (pend_wr && HWDATA !== hold_wdata)) stab_errs++;
      if (wcnt > 0) begin
        HREADY = 1'b0;
        wcnt--;
      end else begin
        HREADY = 1'b1;
        if (pend_wr) begin
          wr_seen++;
          if (wr_seen == err_on_wr) begin
            HRESP = 1'b1;
          end else begin
            mem[pend_addr] = HWDATA;
            wr_addr_q.push_back(pend_addr);
            wr_data_q.push_back(HWDATA);
          end
        end else begin
          HRDATA = word_at(pend_addr);
        end
        pend = 1'b0;
      end
    end else begin
      HREADY = 1'b1;
      if (HTRANS === 2'b10) begin
        pend      = 1'b1;
        pend_wr   = HWRITE;
        pend_addr = HADDR;
        wcnt      = wait_cfg;
        first_dp  = 1'b1;
        n_nonseq++;
        if (!HWRITE) rd_addr_q.push_back(HADDR);
      end
    end
  end

  function automatic bit fill_eff(input bit fill);
`ifdef MFP_AHB_DMA_FILL_EN
    return fill;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: what a LEN-word copy/fill should read and write, and when DONE should appear
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input bit fill, input logic [31:0] pat);
    logic [31:0] s, d;
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    for (int i = 0; i < len; i++) begin
      if (!fill_eff(fill)) exp_ra.push_back(s + 32'(4 * i));
      exp_wa.push_back(d + 32'(4 * i));
      exp_wd.push_back(fill_eff(fill) ? pat : word_at(s + 32'(4 * i)));
    end
  endtask

  function automatic int exp_cycles(input int len, input bit fill, input int waits);
    int phases;
    phases = fill_eff(fill) ? 1 : 2;
    return 2 + len * 2 * phases + len * phases * waits;
  endfunction

  function automatic int log_diff();
    int d;
    d = 0;
    if (wr_addr_q.size() != exp_wa.size()) d++;
    if (rd_addr_q.size() != exp_ra.size()) d++;
    foreach (exp_wa[i])
      if (i < wr_addr_q.size() && (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i])) d++;
    foreach (exp_ra[i])
      if (i < rd_addr_q.size() && rd_addr_q[i] !== exp_ra[i]) d++;
    return d;
  endfunction

  // Issue one command; done_cyc counts the START cycle as cycle 1, -1 on timeout
  task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input int len, input bit fill,
                         input logic [31:0] pat, input int inject_at, output int done_cyc);
    int n;
    @(negedge HCLK);
    wr_seen = 0; n_nonseq = 0; busy_bad = 0; stab_errs = 0;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    CMD_SRC = src; CMD_DST = dst; CMD_LEN = LEN_W'(len); CMD_FILL = fill; CMD_PATTERN = pat;
    CMD_START = 1'b1;
    @(negedge HCLK);
    CMD_START = 1'b0;
    n = 1;
    while (DONE !== 1'b1 && n < 2000) begin
      if (BUSY !== 1'b1) busy_bad++;
      CMD_START = (n == inject_at);
      if (n == inject_at) begin
        CMD_SRC = 32'h3000_0000; CMD_DST = 32'h1234_5670; CMD_LEN = LEN_W'(5);
      end
      @(negedge HCLK);
      n++;
    end
    CMD_START = 1'b0;
    done_cyc = (DONE === 1'b1) ? n + 1 : -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge HCLK);
    total++; if (BUSY !== 1'b0)       $display("FAIL reset_busy: got %b want 0", BUSY); else passed++;
    total++; if (DONE !== 1'b0)       $display("FAIL reset_done: got %b want 0", DONE); else passed++;
    total++; if (ERR !== 1'b0)        $display("FAIL reset_err: got %b want 0", ERR); else passed++;
    total++; if (HTRANS !== 2'b00)    $display("FAIL reset_htrans: got %b want 00", HTRANS); else passed++;
    total++; if (HADDR !== 32'd0)     $display("FAIL reset_haddr: got %h want 0", HADDR); else passed++;
    total++; if (HWRITE !== 1'b0)     $display("FAIL reset_hwrite: got %b want 0", HWRITE); else passed++;
    total++; if (HWDATA !== 32'd0)    $display("FAIL reset_hwdata: got %h want 0", HWDATA); else passed++;
    total++; if ({HSIZE, HBURST, HPROT, HMASTLOCK} !== {3'b010, 3'b000, 4'b0011, 1'b0})
      $display("FAIL const_ctrl: got %b/%b/%b/%b want 010/000/0011/0", HSIZE, HBURST, HPROT, HMASTLOCK);
    else passed++;
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_copy_basic();
    int dc;
    mem[32'h2000_0000] = 32'h1111_1111;
    mem[32'h2000_0004] = 32'h2222_2222;
    mem[32'h2000_0008] = 32'h3333_3333;
    wait_cfg = 0;
    model_copy(32'h2000_0000, 32'hBF40_0000, 3, 1'b0, 32'd0);
    run_cmd(32'h2000_0000, 32'hBF40_0000, 3, 1'b0, 32'd0, 0, dc);
    total++; if (dc !== 14)        $display("FAIL copy_done_cycle: got %0d want 14", dc); else passed++;
    total++; if (ERR !== 1'b0)     $display("FAIL copy_err: got %b want 0", ERR); else passed++;
    total++; if (BUSY !== 1'b0)    $display("FAIL copy_busy_at_done: got %b want 0", BUSY); else passed++;
    total++; if (busy_bad !== 0)   $display("FAIL copy_busy_during: got %0d low cycles want 0", busy_bad); else passed++;
    total++; if (n_nonseq !== 6)   $display("FAIL copy_nonseq: got %0d want 6", n_nonseq); else passed++;
    total++; if (log_diff() !== 0) $display("FAIL copy_log: got %0d diffs want 0", log_diff()); else passed++;
    total++; if (word_at(32'hBF40_0000) !== 32'h1111_1111 || word_at(32'hBF40_0004) !== 32'h2222_2222 ||
                 word_at(32'hBF40_0008) !== 32'h3333_3333)
      $display("FAIL copy_vram: got %h %h %h want 11111111 22222222 33333333",
               word_at(32'hBF40_0000), word_at(32'hBF40_0004), word_at(32'hBF40_0008));
    else passed++;
    @(negedge HCLK);
    total++; if (DONE !== 1'b0)    $display("FAIL copy_done_pulse: got %b want 0", DONE); else passed++;
  endtask

  task automatic test_wait_states();
    int dc;
    wait_cfg = 2;
    model_copy(32'h2000_0010, 32'hBF40_0040, 2, 1'b0, 32'd0);
    run_cmd(32'h2000_0010, 32'hBF40_0040, 2, 1'b0, 32'd0, 0, dc);
    wait_cfg = 0;
    total++; if (dc !== 18)        $display("FAIL wait_done_cycle: got %0d want 18", dc); else passed++;
    total++; if (stab_errs !== 0)  $display("FAIL wait_stable: got %0d unstable cycles want 0", stab_errs); else passed++;
    total++; if (log_diff() !== 0) $display("FAIL wait_log: got %0d diffs want 0", log_diff()); else passed++;
  endtask

  task automatic test_error_abort();
    int dc, seen;
    wait_cfg  = 0;
    err_on_wr = 2;
    model_copy(32'h2000_0020, 32'hBF40_0080, 4, 1'b0, 32'd0);
    while (exp_wa.size() > 1) begin void'(exp_wa.pop_back()); void'(exp_wd.pop_back()); end
    while (exp_ra.size() > 2) void'(exp_ra.pop_back());
    run_cmd(32'h2000_0020, 32'hBF40_0080, 4, 1'b0, 32'd0, 0, dc);
    err_on_wr = 0;
    total++; if (dc !== 10)        $display("FAIL err_done_cycle: got %0d want 10", dc); else passed++;
    total++; if (ERR !== 1'b1)     $display("FAIL err_flag: got %b want 1", ERR); else passed++;
    total++; if (log_diff() !== 0) $display("FAIL err_log: got %0d diffs want 0", log_diff()); else passed++;
    seen = n_nonseq;
    repeat (4) @(negedge HCLK);
    total++; if (n_nonseq !== 4 || seen !== 4) $display("FAIL err_nonseq: got %0d/%0d want 4", seen, n_nonseq); else passed++;
    total++; if (ERR !== 1'b1)     $display("FAIL err_sticky: got %b want 1", ERR); else passed++;
    model_copy(32'h2000_0030, 32'hBF40_00C0, 1, 1'b0, 32'd0);
    run_cmd(32'h2000_0030, 32'hBF40_00C0, 1, 1'b0, 32'd0, 0, dc);
    total++; if (ERR !== 1'b0)     $display("FAIL err_cleared: got %b want 0", ERR); else passed++;
    total++; if (log_diff() !== 0) $display("FAIL err_next_log: got %0d diffs want 0", log_diff()); else passed++;
  endtask

  task automatic test_boundary();
    int dc, seen;
    run_cmd(32'h2000_0000, 32'hBF40_0100, 0, 1'b0, 32'd0, 0, dc);
    total++; if (dc !== 2)        $display("FAIL len0_done_cycle: got %0d want 2", dc); else passed++;
    total++; if (n_nonseq !== 0)  $display("FAIL len0_nonseq: got %0d want 0", n_nonseq); else passed++;
    run_cmd(32'h2000_0003, 32'hBF40_0101, 1, 1'b0, 32'd0, 0, dc);
    total++; if (rd_addr_q.size() < 1 || rd_addr_q[0] !== 32'h2000_0000)
      $display("FAIL unaligned_src: got %h want 20000000", rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hx);
    else passed++;
    total++; if (wr_addr_q.size() < 1 || wr_addr_q[0] !== 32'hBF40_0100)
      $display("FAIL unaligned_dst: got %h want bf400100", wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx);
    else passed++;
    model_copy(32'h2000_0040, 32'hFFFF_FFFC, 2, 1'b0, 32'd0);
    run_cmd(32'h2000_0040, 32'hFFFF_FFFC, 2, 1'b0, 32'd0, 0, dc);
    total++; if (wr_addr_q.size() < 2 || wr_addr_q[1] !== 32'h0000_0000)
      $display("FAIL wrap_dst: got %h want 00000000", wr_addr_q.size() > 1 ? wr_addr_q[1] : 32'hx);
    else passed++;
    total++; if (log_diff() !== 0 || ERR !== 1'b0) $display("FAIL wrap_log: got %0d diffs err=%b want 0/0", log_diff(), ERR); else passed++;
    // START presented while DONE is high must be dropped
    seen = n_nonseq;
    CMD_START = 1'b1; CMD_LEN = LEN_W'(2);
    @(negedge HCLK);
    CMD_START = 1'b0;
    total++; if (BUSY !== 1'b0)   $display("FAIL start_in_fin_busy: got %b want 0", BUSY); else passed++;
    repeat (3) @(negedge HCLK);
    total++; if (n_nonseq !== seen) $display("FAIL start_in_fin_bus: got %0d want %0d", n_nonseq, seen); else passed++;
    model_copy(32'h2000_0050, 32'hBF40_0200, 3, 1'b0, 32'd0);
    run_cmd(32'h2000_0050, 32'hBF40_0200, 3, 1'b0, 32'd0, 5, dc);
    total++; if (dc !== 14)        $display("FAIL busy_start_cycle: got %0d want 14", dc); else passed++;
    total++; if (log_diff() !== 0) $display("FAIL busy_start_log: got %0d diffs want 0", log_diff()); else passed++;
  endtask

  task automatic test_reset_mid();
    int n, dc;
    @(negedge HCLK);
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    CMD_SRC = 32'h2000_0060; CMD_DST = 32'hBF40_0300; CMD_LEN = LEN_W'(2); CMD_FILL = 1'b0;
    CMD_START = 1'b1;
    @(negedge HCLK);
    CMD_START = 1'b0;
    n = 0;
    while (!(HTRANS === 2'b10 && HWRITE === 1'b1 && wr_addr_q.size() == 1) && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    total++; if (n >= 100) $display("FAIL rstmid_reach_wr_a: got timeout want word1 write address"); else passed++;
    #1 HRESETn = 1'b0;
    #1;
    total++; if (HTRANS !== 2'b00) $display("FAIL rstmid_htrans: got %b want 00", HTRANS); else passed++;
    total++; if (BUSY !== 1'b0)    $display("FAIL rstmid_busy: got %b want 0", BUSY); else passed++;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    model_copy(32'h2000_0070, 32'hBF40_0340, 1, 1'b0, 32'd0);
    run_cmd(32'h2000_0070, 32'hBF40_0340, 1, 1'b0, 32'd0, 0, dc);
    total++; if (dc !== 6)         $display("FAIL rstmid_after_cycle: got %0d want 6", dc); else passed++;
    total++; if (log_diff() !== 0) $display("FAIL rstmid_after_log: got %0d diffs want 0", log_diff()); else passed++;
  endtask

  task automatic test_random();
    int dc, len, w;
    logic [31:0] s, d;
    for (int it = 0; it < 6; it++) begin
      len = int'($urandom_range(1, 8));
      w   = int'($urandom_range(0, 2));
      s   = 32'h2000_0400 + 32'(4 * $urandom_range(0, 255));
      d   = 32'hBF40_1000 + 32'(4 * $urandom_range(0, 255));
      wait_cfg = w;
      model_copy(s, d, len, 1'b0, 32'd0);
      run_cmd(s, d, len, 1'b0, 32'd0, 0, dc);
      total++; if (dc !== exp_cycles(len, 1'b0, w) || log_diff() !== 0 || ERR !== 1'b0 || stab_errs !== 0)
        $display("FAIL random_copy%0d: got cyc=%0d diffs=%0d err=%b unstable=%0d want cyc=%0d 0 0 0",
                 it, dc, log_diff(), ERR, stab_errs, exp_cycles(len, 1'b0, w));
      else passed++;
    end
    wait_cfg = 0;
  endtask

  task automatic test_fill();
    int dc;
    model_copy(32'h2000_0800, 32'h8000_1000, 4, 1'b1, 32'hA5A5_A5A5);
    run_cmd(32'h2000_0800, 32'h8000_1000, 4, 1'b1, 32'hA5A5_A5A5, 0, dc);
    total++; if (dc !== exp_cycles(4, 1'b1, 0))
      $display("FAIL fill_done_cycle: got %0d want %0d", dc, exp_cycles(4, 1'b1, 0));
    else passed++;
    total++; if (log_diff() !== 0) $display("FAIL fill_log: got %0d diffs want 0", log_diff()); else passed++;
    total++; if (n_nonseq !== (fill_eff(1'b1) ? 4 : 8))
      $display("FAIL fill_nonseq: got %0d want %0d", n_nonseq, fill_eff(1'b1) ? 4 : 8);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_copy_basic();
    test_wait_states();
    test_error_abort();
    test_boundary();
    test_reset_mid();
    test_random();
    test_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
